// File: rtl/i2c_flash_pkg.sv
// Shared constants and helpers for the I2C flash slave front end.
package i2c_flash_pkg;

    // Default 7-bit slave address the flash answers to
    localparam logic [6:0] DEVICE_ADDR_DEFAULT = 7'h18;

    // Reserved general-call address
    localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

    // Position of the R/W bit inside the address byte
    localparam int unsigned RW_BIT = 0;

    // R/W bit encodings as seen on the bus
    typedef enum logic {
        RW_WRITE = 1'b0,
        RW_READ  = 1'b1
    } rw_dir_e;

    // True when the address byte is a general call (address 0, write direction)
    function automatic logic is_general_call(input logic [7:0] addr_byte);
        return (addr_byte[7:1] == GENERAL_CALL_ADDR) &&
               (addr_byte[RW_BIT] == RW_WRITE);
    endfunction

endpackage

// File: rtl/device_id.sv
// Device-ID stage: captures the first byte after START, latches R/W and
// decodes own-address / general-call matches for the controller.
module device_id
    import i2c_flash_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = DEVICE_ADDR_DEFAULT,
    parameter bit         GC_ENABLE   = 1'b1
) (
    input  logic       SCL,
    input  logic       Reset,
    input  logic [7:0] ShiftRegOut,
    input  logic       LoadDeviceId,
    output logic       WR,
    output logic [6:0] AddrLatched,
    output logic       AddrMatch,
    output logic       GeneralCall,
    output logic       AddrValid
);

    logic load_prev;

    // Capture address byte and decode matches on every edge that samples a load request
    always_ff @(posedge SCL or posedge Reset) begin
        if (Reset) begin
            WR          <= 1'b0;
            AddrLatched <= '0;
            AddrMatch   <= 1'b0;
            GeneralCall <= 1'b0;
        end else if (LoadDeviceId) begin
            WR          <= ShiftRegOut[RW_BIT];
            AddrLatched <= ShiftRegOut[7:1];
            AddrMatch   <= (ShiftRegOut[7:1] == DEVICE_ADDR);
            GeneralCall <= GC_ENABLE && is_general_call(ShiftRegOut);
        end
    end

    // Load edge detector: pulse AddrValid for one cycle after a 0->1 sampled load
    always_ff @(posedge SCL or posedge Reset) begin
        if (Reset) begin
            load_prev <= 1'b0;
            AddrValid <= 1'b0;
        end else begin
            load_prev <= LoadDeviceId;
            AddrValid <= LoadDeviceId && !load_prev;
        end
    end

endmodule

// File: tb/tb_device_id.sv
// Scoreboard bench for device_id: a reference model pushes the expected
// outputs at each rising SCL, a monitor pops and compares on the falling edge.
module tb_device_id;

    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic       match;
        logic       gc;
        logic       valid;
    } exp_t;

    logic       scl = 1'b0;
    logic       rst = 1'b0;
    logic       ld  = 1'b0;
    logic [7:0] sro = 8'h00;

    logic       wr_a, match_a, gc_a, valid_a;
    logic [6:0] addr_a;
    logic       wr_b, match_b, gc_b, valid_b;
    logic [6:0] addr_b;

    int checks = 0;
    int passes = 0;

    exp_t q[$];

    // Reference model state: what the latched outputs should hold
    logic       m_wr = 1'b0;
    logic [6:0] m_addr = 7'h00;
    logic       m_match = 1'b0;
    logic       m_gc = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_prev = 1'b0;

    device_id #(.DEVICE_ADDR(7'h18), .GC_ENABLE(1'b1)) dut (
        .SCL(scl), .Reset(rst), .ShiftRegOut(sro), .LoadDeviceId(ld),
        .WR(wr_a), .AddrLatched(addr_a), .AddrMatch(match_a),
        .GeneralCall(gc_a), .AddrValid(valid_a)
    );

    device_id #(.DEVICE_ADDR(7'h18), .GC_ENABLE(1'b0)) dut_nogc (
        .SCL(scl), .Reset(rst), .ShiftRegOut(sro), .LoadDeviceId(ld),
        .WR(wr_b), .AddrLatched(addr_b), .AddrMatch(match_b),
        .GeneralCall(gc_b), .AddrValid(valid_b)
    );

    always #10 scl = ~scl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    // Reference model: async reset clears, a sampled load captures the byte
    initial begin
        forever begin
            @(posedge scl or posedge rst);
            if (rst) begin
                m_wr = 1'b0; m_addr = 7'h00; m_match = 1'b0;
                m_gc = 1'b0; m_valid = 1'b0; m_prev = 1'b0;
            end else if (scl) begin
                m_valid = ld && !m_prev;
                if (ld) begin
                    m_wr    = sro[0];
                    m_addr  = 7'(sro / 2);
                    m_match = ((sro / 2) == 8'h18);
                    m_gc    = (sro == 8'h00);
                end
                m_prev = ld;
            end
            if (scl)
                q.push_back('{wr: m_wr, addr: m_addr, match: m_match, gc: m_gc, valid: m_valid});
        end
    end

    // Monitor: compare both instances against the expected record each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge scl);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr",         32'(wr_a),    32'(e.wr));
                chk("addr",       32'(addr_a),  32'(e.addr));
                chk("match",      32'(match_a), 32'(e.match));
                chk("gc",         32'(gc_a),    32'(e.gc));
                chk("valid",      32'(valid_a), 32'(e.valid));
                chk("nogc_match", 32'(match_b), 32'(e.match));
                chk("nogc_gc",    32'(gc_b),    32'h0);
                chk("nogc_valid", 32'(valid_b), 32'(e.valid));
            end
        end
    end

    task automatic drive(input logic l, input logic [7:0] d);
        @(negedge scl);
        ld  = l;
        sro = d;
    endtask

    // Pulse reset between edges and confirm outputs clear without an SCL edge
    task automatic reset_pulse();
        @(negedge scl);
        #3 rst = 1'b1;
        #1;
        chk("arst_wr",    32'(wr_a),    32'h0);
        chk("arst_addr",  32'(addr_a),  32'h0);
        chk("arst_match", 32'(match_a), 32'h0);
        chk("arst_gc",    32'(gc_a),    32'h0);
        chk("arst_valid", 32'(valid_a), 32'h0);
        chk("arst_b_wr",  32'(wr_b),    32'h0);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int unsigned r;
        rst = 1'b1;
        ld  = 1'b1;
        sro = 8'hFF;
        repeat (4) drive(1'b1, 8'hFF);
        @(negedge scl);
        rst = 1'b0;
        drive(1'b0, 8'hFF);
        drive(1'b0, 8'h31);
        drive(1'b1, 8'h31);
        drive(1'b1, 8'h31);
        drive(1'b1, 8'h30);
        drive(1'b1, 8'hA1);
        drive(1'b0, 8'h31);
        drive(1'b0, 8'h31);
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        drive(1'b1, 8'h31);
        drive(1'b0, 8'h31);
        reset_pulse();
        drive(1'b0, 8'h31);
        drive(1'b1, 8'h31);
        drive(1'b1, 8'h31);
        drive(1'b0, 8'h31);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_pulse();
            end else begin
                r = $urandom_range(0, 7);
                case (r)
                    0: d = 8'h30;
                    1: d = 8'h31;
                    2: d = 8'h00;
                    3: d = 8'h01;
                    default: d = 8'($urandom);
                endcase
                drive($urandom_range(0, 2) != 0, d);
            end
        end

        repeat (2) @(negedge scl);
        #1;
        chk("queue_drain", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
